id_stage: RTL and testbench

//  Decode stage directly downstream of the instruction-fetch unit. Captures the fetched

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/id_stage_reg_file.sv | 42 ++++
 rtl/id_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode constants for the decode stage: opcodes, funct codes,
// ALU operation encodings and the control-word layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_OR  = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;
    localparam logic [3:0] ALU_SLT = 4'h7;

    // Bit positions inside the 10-bit control word
    localparam int CTRL_W          = 10;
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_BRANCH     = 4;

    // Field order matches the bit indices above (MSB first)
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [3:0] alu_op;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: two combinational read ports, one write port.
// Register 0 is hard-wired to zero; a write in the same cycle as a read
// of the same register is bypassed to the read port.
module reg_file
    import mips_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [0:NREGS-1];
    logic        wr_en;

    assign wr_en = we_i & (wa_i != 5'd0);

    // Storage: cleared on reset, written on the rising edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports with write-through bypass and zero register
    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (ra1_i != 5'd0) rd1_o = (wr_en && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
        if (ra2_i != 5'd0) rd2_o = (wr_en && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID capture, register read, control decode, ID/EX
// register and load-use hazard detection.
module id_stage
    import mips_pkg::*;
#(
    parameter int PC_W  = 4,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] PC_4,
    input  logic            if_valid,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [31:0]     wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [PC_W-1:0] ex_pc_4,
    output logic [31:0]     ex_rs_data,
    output logic [31:0]     ex_rt_data,
    output logic [31:0]     ex_imm,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_dest,
    output logic [9:0]      ex_ctrl,
    output logic            ex_jump,
    output logic [PC_W-1:0] ex_jump_addr,
    output logic            ex_illegal
);

    // IF/ID register
    logic [31:0]     ifid_instr_q;
    logic [PC_W-1:0] ifid_pc_q;
    logic            ifid_valid_q;

    // ID/EX register
    logic            ex_valid_q, ex_jump_q, ex_illegal_q;
    logic [PC_W-1:0] ex_pc_q, ex_jaddr_q;
    logic [31:0]     ex_rs_data_q, ex_rt_data_q, ex_imm_q;
    logic [4:0]      ex_rs_q, ex_rt_q, ex_dest_q;
    ctrl_t           ex_ctrl_q;

    // Decoded next-state for ID/EX
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data_d, rt_data_d;
    logic [4:0]  dest_d;
    ctrl_t       ctrl_d;
    logic        jump_d, illegal_d, rt_used, issue;

    assign op    = ifid_instr_q[31:26];
    assign rs    = ifid_instr_q[25:21];
    assign rt    = ifid_instr_q[20:16];
    assign rd    = ifid_instr_q[15:11];
    assign funct = ifid_instr_q[5:0];

    reg_file #(.NREGS(NREGS)) u_rf (
        .clk_i (clk),
        .rst_ni(reset_n),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_data_d),
        .rd2_o (rt_data_d),
        .we_i  (wb_we),
        .wa_i  (wb_addr),
        .wd_i  (wb_data)
    );

    // Opcode/funct decode of the instruction held in IF/ID
    always_comb begin
        ctrl_d    = '0;
        dest_d    = '0;
        jump_d    = 1'b0;
        illegal_d = 1'b0;
        rt_used   = 1'b0;
        case (op)
            OP_RTYPE: begin
                rt_used          = 1'b1;
                dest_d           = rd;
                ctrl_d.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl_d.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_d.alu_op = ALU_SUB;
                    FN_AND:  ctrl_d.alu_op = ALU_AND;
                    FN_OR:   ctrl_d.alu_op = ALU_OR;
                    FN_SLT:  ctrl_d.alu_op = ALU_SLT;
                    default: begin
                        ctrl_d    = '0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dest_d            = rt;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                rt_used          = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                rt_used       = 1'b1;
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                dest_d           = rt;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_ADD;
            end
            OP_J:    jump_d    = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // Load in EX whose destination feeds the instruction in ID: hold one cycle
    assign stall = ifid_valid_q & ex_valid_q & ex_ctrl_q.mem_read & (ex_dest_q != 5'd0) &
                   ((ex_dest_q == rs) | ((ex_dest_q == rt) & rt_used));
    assign issue = ifid_valid_q & ~stall & ~flush;

    // IF/ID: flush kills the held instruction, stall freezes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else if (flush) begin
            ifid_valid_q <= 1'b0;
        end else if (!stall) begin
            ifid_instr_q <= instruction;
            ifid_pc_q    <= PC_4;
            ifid_valid_q <= if_valid;
        end
    end

    // ID/EX: decoded instruction when issuing, an all-zero bubble otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || !issue) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_dest_q    <= '0;
            ex_ctrl_q    <= '0;
            ex_jump_q    <= 1'b0;
            ex_jaddr_q   <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q   <= 1'b1;
            ex_pc_q      <= ifid_pc_q;
            ex_rs_data_q <= rs_data_d;
            ex_rt_data_q <= rt_data_d;
            ex_imm_q     <= sext16(ifid_instr_q[15:0]);
            ex_rs_q      <= rs;
            ex_rt_q      <= rt;
            ex_dest_q    <= dest_d;
            ex_ctrl_q    <= ctrl_d;
            ex_jump_q    <= jump_d;
            ex_jaddr_q   <= ifid_instr_q[PC_W-1:0];
            ex_illegal_q <= illegal_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc_4      = ex_pc_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dest      = ex_dest_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_jump      = ex_jump_q;
    assign ex_jump_addr = ex_jaddr_q;
    assign ex_illegal   = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver feeds directed and random
// instructions through a transaction-level model that pushes expected
// ID/EX contents; a monitor pops them whenever the DUT shows ex_valid.
module tb_id_stage;
    import mips_pkg::*;

    localparam int PC_W = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [31:0]     instruction;
    logic [PC_W-1:0] PC_4;
    logic            if_valid, flush, wb_we;
    logic [4:0]      wb_addr;
    logic [31:0]     wb_data;
    logic            stall, ex_valid, ex_jump, ex_illegal;
    logic [PC_W-1:0] ex_pc_4, ex_jump_addr;
    logic [31:0]     ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]      ex_rs, ex_rt, ex_dest;
    logic [9:0]      ex_ctrl;

    id_stage #(.PC_W(PC_W), .NREGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .PC_4(PC_4),
        .if_valid(if_valid), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_pc_4(ex_pc_4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
        .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_BAD} kind_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     rsd, rtd, imm;
        logic [4:0]      rs, rt, dest;
        logic [9:0]      ctrl;
        logic            jump;
        logic [PC_W-1:0] jaddr;
        logic            illegal;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [31:0]     ref_regs [32];
    logic            id_v, last_v, last_load, stall_seen, mon_en;
    logic [31:0]     id_i;
    logic [PC_W-1:0] id_pc, pc_cnt;
    logic [4:0]      last_dest;
    int              total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] ins);
        case (ins[31:26])
            OP_RTYPE: case (ins[5:0])
                FN_ADD: return K_ADD;
                FN_SUB: return K_SUB;
                FN_AND: return K_AND;
                FN_OR:  return K_OR;
                FN_SLT: return K_SLT;
                default: return K_BAD;
            endcase
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            OP_BEQ:  return K_BEQ;
            OP_ADDI: return K_ADDI;
            OP_J:    return K_J;
            default: return K_BAD;
        endcase
    endfunction

    // What ID/EX should hold for an instruction, given current register contents
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        exp_t e;
        kind_t k;
        logic rw, mr, mw, m2r, as, br;
        logic [3:0] alu;
        k   = kind_of(ins);
        rw  = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_ADDI};
        mr  = (k == K_LW);
        mw  = (k == K_SW);
        m2r = (k == K_LW);
        as  = k inside {K_LW, K_SW, K_ADDI};
        br  = (k == K_BEQ);
        case (k)
            K_ADD, K_LW, K_SW, K_ADDI: alu = ALU_ADD;
            K_SUB, K_BEQ:              alu = ALU_SUB;
            K_AND:                     alu = ALU_AND;
            K_OR:                      alu = ALU_OR;
            K_SLT:                     alu = ALU_SLT;
            default:                   alu = 4'h0;
        endcase
        e.pc   = pc;
        e.rs   = ins[25:21];
        e.rt   = ins[20:16];
        e.rsd  = ref_regs[ins[25:21]];
        e.rtd  = ref_regs[ins[20:16]];
        e.imm  = 32'($signed(ins[15:0]));
        if (ins[31:26] == OP_RTYPE)        e.dest = ins[15:11];
        else if (k == K_LW || k == K_ADDI) e.dest = ins[20:16];
        else                               e.dest = 5'd0;
        e.ctrl    = {rw, mr, mw, m2r, as, br, alu};
        e.jump    = (k == K_J);
        e.jaddr   = ins[PC_W-1:0];
        e.illegal = (k == K_BAD);
        return e;
    endfunction

    function automatic logic model_stall();
        logic [5:0] op;
        logic rt_used;
        op = id_i[31:26];
        rt_used = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
        return id_v && last_v && last_load && last_dest != 5'd0 &&
               (last_dest == id_i[25:21] || (last_dest == id_i[20:16] && rt_used));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_regs[i] = '0;
        id_v = 1'b0; id_i = '0; id_pc = '0;
        last_v = 1'b0; last_load = 1'b0; last_dest = '0;
        exp_q.delete();
    endtask

    // One clock cycle: check stall, drive inputs, advance the model across the edge
    task automatic cyc(input logic [31:0] ins, input logic [PC_W-1:0] pc, input logic ifv,
                       input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic st;
        exp_t e;
        @(negedge clk);
        st = model_stall();
        stall_seen = stall;
        chk("stall", 32'(stall), 32'(st));
        instruction = ins; PC_4 = pc; if_valid = ifv; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        if (we && wa != 5'd0) ref_regs[wa] = wd;
        if (id_v && !st && !fl) begin
            e = ref_decode(id_i, id_pc);
            exp_q.push_back(e);
            last_v = 1'b1;
            last_load = (id_i[31:26] == OP_LW);
            last_dest = e.dest;
        end else begin
            last_v = 1'b0;
        end
        if (fl) id_v = 1'b0;
        else if (!st) begin
            id_v = ifv; id_i = ins; id_pc = pc;
        end
    endtask

    // Fetch-unit behaviour: re-present the instruction while stall holds
    task automatic fetch(input logic [31:0] ins, output int stalls);
        stalls = 0;
        for (int k = 0; k < 4 && model_stall(); k++) begin
            cyc(ins, pc_cnt, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            stalls += int'(stall_seen);
        end
        cyc(ins, pc_cnt, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        stalls += int'(stall_seen);
        pc_cnt++;
    endtask

    task automatic idle(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        cyc(32'd0, pc_cnt, 1'b0, 1'b0, we, wa, wd);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_stall"}, 32'(stall), 0);
        chk({p, "_ex_valid"}, 32'(ex_valid), 0);
        chk({p, "_ex_pc_4"}, 32'(ex_pc_4), 0);
        chk({p, "_ex_rs_data"}, ex_rs_data, 0);
        chk({p, "_ex_rt_data"}, ex_rt_data, 0);
        chk({p, "_ex_imm"}, ex_imm, 0);
        chk({p, "_ex_rs_rt_dest"}, 32'({ex_rs, ex_rt, ex_dest}), 0);
        chk({p, "_ex_ctrl"}, 32'(ex_ctrl), 0);
        chk({p, "_ex_jump"}, 32'({ex_jump, ex_jump_addr}), 0);
        chk({p, "_ex_illegal"}, 32'(ex_illegal), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        logic [5:0] fn;
        int sel;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        sel = $urandom_range(0, 11);
        case (sel)
            0: fn = FN_ADD;
            1: fn = FN_SUB;
            2: fn = FN_AND;
            3: fn = FN_OR;
            default: fn = FN_SLT;
        endcase
        case (sel)
            0, 1, 2, 3, 4: return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
            5, 6:          return {OP_LW, rs, rt, imm};
            7:             return {OP_SW, rs, rt, imm};
            8:             return {OP_BEQ, rs, rt, imm};
            9:             return {OP_ADDI, rs, rt, imm};
            10:            return {OP_J, 26'($urandom)};
            default:       return $urandom;
        endcase
    endfunction

    // Monitor: compare every real ID/EX slot against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (ex_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_issue: ex_valid=1 with empty scoreboard at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ex_pc_4", 32'(ex_pc_4), 32'(mon_e.pc));
                    chk("ex_rs_data", ex_rs_data, mon_e.rsd);
                    chk("ex_rt_data", ex_rt_data, mon_e.rtd);
                    chk("ex_imm", ex_imm, mon_e.imm);
                    chk("ex_rs", 32'(ex_rs), 32'(mon_e.rs));
                    chk("ex_rt", 32'(ex_rt), 32'(mon_e.rt));
                    chk("ex_dest", 32'(ex_dest), 32'(mon_e.dest));
                    chk("ex_ctrl", 32'(ex_ctrl), 32'(mon_e.ctrl));
                    chk("ex_jump", 32'(ex_jump), 32'(mon_e.jump));
                    chk("ex_jump_addr", 32'(ex_jump_addr), 32'(mon_e.jaddr));
                    chk("ex_illegal", 32'(ex_illegal), 32'(mon_e.illegal));
                end
            end else begin
                chk("bubble_ctrl", 32'(ex_ctrl), 0);
                chk("bubble_flags", 32'({ex_jump, ex_illegal}), 0);
                chk("bubble_dest", 32'(ex_dest), 0);
            end
        end
    end

    initial begin
        int n;
        logic [31:0] cur, ins;
        logic cur_v, fl, we;
        logic [4:0] wa;
        mon_en = 1'b0; reset_n = 1'b0; stall_seen = 1'b0;
        instruction = '0; PC_4 = '0; if_valid = 1'b0; flush = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        pc_cnt = '0; cur = '0; cur_v = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check_zero("por");
        reset_n = 1'b1; mon_en = 1'b1;

        // write r5 then add r3,r5,r5
        idle(1'b1, 5'd5, 32'h1234);
        fetch(32'h00a51820, n);
        // same-cycle write-back bypass to r7, write to r0 ignored
        fetch(32'h00e04020, n);
        idle(1'b1, 5'd7, 32'hdead);
        fetch(32'h00004820, n);
        idle(1'b1, 5'd0, 32'hbeef);
        // addi r1,r0,-1 and an undefined opcode
        fetch(32'h2001ffff, n);
        ins = {6'h3f, 26'($urandom)};
        fetch(ins, n);
        // lw r2,4(r1) ; add r4,r2,r0 ; addi r10,r0,1 -> one stall cycle
        fetch(32'h8c220004, n);
        fetch(32'h00402020, n);
        fetch(32'h200a0001, n);
        chk("t3_stall_cycles", 32'(n), 1);
        idle(1'b0, 5'd0, 32'd0);
        // flush while stalled
        fetch(32'h8c220000, n);
        fetch(32'h00402020, n);
        cyc(32'h200b0002, pc_cnt, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("t5_stall_with_flush", 32'(stall_seen), 1);
        idle(1'b0, 5'd0, 32'd0);
        chk("t5_stall_after_flush", 32'(stall_seen), 0);
        idle(1'b0, 5'd0, 32'd0);

        // reset mid-stream with ID/EX loaded and stall asserted
        fetch(32'h8c220000, n);
        fetch(32'h00402020, n);
        @(negedge clk);
        #2;
        chk("t1_preload_valid", 32'(ex_valid), 1);
        mon_en = 1'b0;
        reset_n = 1'b0;
        if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
        #1;
        check_zero("midrst");
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        chk("post_rst_ex_valid", 32'(ex_valid), 0);
        chk("post_rst_stall", 32'(stall), 0);
        mon_en = 1'b1;
        fetch(32'h00a51820, n);
        idle(1'b0, 5'd0, 32'd0);

        // randomized stream
        for (int c = 0; c < 3000; c++) begin
            fl = ($urandom_range(0, 19) == 0);
            if (!model_stall()) begin
                cur = rand_instr();
                cur_v = ($urandom_range(0, 6) != 0);
                pc_cnt++;
            end
            we = ($urandom_range(0, 2) == 0);
            wa = 5'($urandom_range(0, 7));
            cyc(cur, pc_cnt, cur_v, fl, we, wa, $urandom);
        end

        repeat (4) idle(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
